// File: rtl/cpu6_trap_sequencer.sv
// Trap sequencer for cpu6: qualifies timer/external interrupts, drains the pipeline,
// then redirects fetch to mtvec (trap entry) or mepc (mret return).
module cpu6_trap_sequencer #(
  parameter int ACK_TIMEOUT = 15,
  parameter int HOLDOFF     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tmr_irq_r,
  input  logic        ext_irq_r,
  input  logic        csr_mtie_r,
  input  logic        csr_meie_r,
  input  logic        csr_mstatus_mie_r,
  input  logic        mret_reqE,
  input  logic [31:0] resume_pcE,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  input  logic        empty_pipeline_ackW,
  output logic        empty_pipeline_reqE,
  output logic        stallF,
  output logic [31:0] excp_mepc,
  output logic        excp_mepc_ena,
  output logic [31:0] mcause,
  output logic        mcause_ena,
  output logic        mret_ena,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_err,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    IRQ_DRAIN = 3'd1,
    IRQ_TRAP  = 3'd2,
    RET_DRAIN = 3'd3,
    RET_JMP   = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);
  localparam logic [2:0] HOLD    = 3'(HOLDOFF);

  state_t      state;
  logic [2:0]  holdoff;
  logic [7:0]  wait_cnt;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic        ext_hit;
  logic        pending;
  logic        drain_done;

  assign ext_hit    = ext_irq_r & csr_meie_r;
  assign pending    = csr_mstatus_mie_r & (ext_hit | (tmr_irq_r & csr_mtie_r));
  assign drain_done = empty_pipeline_ackW || (wait_cnt == TIMEOUT);
  assign fsm_state  = state;

  // Only the redirect target is muxed straight from the CSR inputs, during the strobe cycle.
  always_comb begin
    redirect_pc = 32'h0;
    if (state == IRQ_TRAP)     redirect_pc = csr_mtvec & 32'hFFFF_FFFC;
    else if (state == RET_JMP) redirect_pc = csr_mepc & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state               <= IDLE;
      holdoff             <= 3'd0;
      wait_cnt            <= 8'd0;
      epc_q               <= 32'h0;
      cause_q             <= 32'h0;
      empty_pipeline_reqE <= 1'b0;
      stallF              <= 1'b0;
      excp_mepc           <= 32'h0;
      excp_mepc_ena       <= 1'b0;
      mcause              <= 32'h0;
      mcause_ena          <= 1'b0;
      mret_ena            <= 1'b0;
      redirect_valid      <= 1'b0;
      drain_err           <= 1'b0;
    end else begin
      empty_pipeline_reqE <= 1'b0;
      excp_mepc           <= 32'h0;
      excp_mepc_ena       <= 1'b0;
      mcause              <= 32'h0;
      mcause_ena          <= 1'b0;
      mret_ena            <= 1'b0;
      redirect_valid      <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (holdoff != 3'd0) holdoff <= holdoff - 3'd1;
          // mret is honoured even during holdoff and beats a simultaneous interrupt.
          if (mret_reqE) begin
            state               <= RET_DRAIN;
            stallF              <= 1'b1;
            empty_pipeline_reqE <= 1'b1;
          end else if (pending && holdoff == 3'd0) begin
            epc_q               <= resume_pcE;
            cause_q             <= ext_hit ? 32'h8000_000B : 32'h8000_0007;
            state               <= IRQ_DRAIN;
            stallF              <= 1'b1;
            empty_pipeline_reqE <= 1'b1;
          end
        end
        IRQ_DRAIN, RET_DRAIN: begin
          if (drain_done) begin
            wait_cnt       <= 8'd0;
            redirect_valid <= 1'b1;
            if (!empty_pipeline_ackW) drain_err <= 1'b1;
            if (state == IRQ_DRAIN) begin
              state         <= IRQ_TRAP;
              excp_mepc     <= epc_q;
              excp_mepc_ena <= 1'b1;
              mcause        <= cause_q;
              mcause_ena    <= 1'b1;
            end else begin
              state    <= RET_JMP;
              mret_ena <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        IRQ_TRAP, RET_JMP: begin
          state   <= IDLE;
          stallF  <= 1'b0;
          holdoff <= HOLD;
        end
        default: begin
          state  <= IDLE;
          stallF <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6_trap_sequencer.sv
// Directed bench for cpu6_trap_sequencer: per-cycle vector table plus hand-written
// sequences for timeout, MIE masking and reset during a drain.
module tb_cpu6_trap_sequencer;

  localparam int ACK_TIMEOUT = 15;
  localparam int HOLDOFF     = 2;
  localparam int OW          = 103;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tmr_irq_r = 1'b0, ext_irq_r = 1'b0;
  logic        csr_mtie_r = 1'b0, csr_meie_r = 1'b0, csr_mstatus_mie_r = 1'b0;
  logic        mret_reqE = 1'b0;
  logic [31:0] resume_pcE = 32'h0;
  logic [31:0] csr_mtvec = 32'h0000_0401;
  logic [31:0] csr_mepc = 32'h0000_0124;
  logic        empty_pipeline_ackW = 1'b0;
  logic        empty_pipeline_reqE, stallF, excp_mepc_ena, mcause_ena, mret_ena;
  logic        redirect_valid, drain_err;
  logic [31:0] excp_mepc, mcause, redirect_pc;
  logic [2:0]  fsm_state;

  int checks = 0;
  int failures = 0;
  logic [OW-1:0] exp_q[$];

  cpu6_trap_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset(reset),
    .tmr_irq_r(tmr_irq_r), .ext_irq_r(ext_irq_r),
    .csr_mtie_r(csr_mtie_r), .csr_meie_r(csr_meie_r), .csr_mstatus_mie_r(csr_mstatus_mie_r),
    .mret_reqE(mret_reqE), .resume_pcE(resume_pcE),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .empty_pipeline_ackW(empty_pipeline_ackW),
    .empty_pipeline_reqE(empty_pipeline_reqE), .stallF(stallF),
    .excp_mepc(excp_mepc), .excp_mepc_ena(excp_mepc_ena),
    .mcause(mcause), .mcause_ena(mcause_ena), .mret_ena(mret_ena),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .drain_err(drain_err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // {tmr, ext, mtie, meie, mie, mret, ack}; expected strobes {req, stall, epc_ena, cause_ena, mret_ena, rvalid}
  typedef struct {
    logic [6:0]  in_bits;
    logic [31:0] resume;
    logic [5:0]  exp_strb;
    logic [31:0] exp_epc;
    logic [31:0] exp_cause;
    logic [31:0] exp_redir;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [OW-1:0] outs();
    return {empty_pipeline_reqE, stallF, excp_mepc_ena, mcause_ena, mret_ena,
            redirect_valid, drain_err, excp_mepc, mcause, redirect_pc};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [6:0] b, input logic [31:0] pc);
    {tmr_irq_r, ext_irq_r, csr_mtie_r, csr_meie_r, csr_mstatus_mie_r, mret_reqE,
     empty_pipeline_ackW} = b;
    resume_pcE = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    apply(7'b0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int found;
    int cnt;

    vecs[0]  = '{7'b0101100, 32'h120, 6'b110000, 32'h0,   32'h0,          32'h0};
    vecs[1]  = '{7'b0101100, 32'h120, 6'b010000, 32'h0,   32'h0,          32'h0};
    vecs[2]  = '{7'b0101100, 32'h120, 6'b010000, 32'h0,   32'h0,          32'h0};
    vecs[3]  = '{7'b0101101, 32'h120, 6'b011101, 32'h120, 32'h8000_000B, 32'h400};
    vecs[4]  = '{7'b0101100, 32'h120, 6'b000000, 32'h0,   32'h0,          32'h0};
    vecs[5]  = '{7'b0101100, 32'h120, 6'b000000, 32'h0,   32'h0,          32'h0};
    vecs[6]  = '{7'b0101100, 32'h120, 6'b000000, 32'h0,   32'h0,          32'h0};
    vecs[7]  = '{7'b1110100, 32'h200, 6'b110000, 32'h0,   32'h0,          32'h0};
    vecs[8]  = '{7'b0010101, 32'h200, 6'b011101, 32'h200, 32'h8000_0007, 32'h400};
    vecs[9]  = '{7'b0010100, 32'h0,   6'b000000, 32'h0,   32'h0,          32'h0};
    vecs[10] = '{7'b0010101, 32'h0,   6'b000000, 32'h0,   32'h0,          32'h0};
    vecs[11] = '{7'b0010100, 32'h0,   6'b000000, 32'h0,   32'h0,          32'h0};
    vecs[12] = '{7'b0111110, 32'h500, 6'b110000, 32'h0,   32'h0,          32'h0};
    vecs[13] = '{7'b0111101, 32'h500, 6'b010011, 32'h0,   32'h0,          32'h124};
    vecs[14] = '{7'b0010100, 32'h0,   6'b000000, 32'h0,   32'h0,          32'h0};
    vecs[15] = '{7'b0010100, 32'h0,   6'b000000, 32'h0,   32'h0,          32'h0};
    vecs[16] = '{7'b0010100, 32'h0,   6'b000000, 32'h0,   32'h0,          32'h0};
    vecs[17] = '{7'b1111100, 32'h300, 6'b110000, 32'h0,   32'h0,          32'h0};
    vecs[18] = '{7'b1111101, 32'h300, 6'b011101, 32'h300, 32'h8000_000B, 32'h400};
    vecs[19] = '{7'b0000000, 32'h0,   6'b000000, 32'h0,   32'h0,          32'h0};

    do_reset();
    check("reset_state", {outs(), fsm_state}, {{OW{1'b0}}, 3'd0});

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].in_bits, vecs[i].resume);
      exp_q.push_back({vecs[i].exp_strb, 1'b0, vecs[i].exp_epc, vecs[i].exp_cause,
                       vecs[i].exp_redir});
      tick();
      check($sformatf("vec%0d", i), outs(), exp_q.pop_front());
    end

    // MIE clear masks both sources.
    apply(7'b1111000, 32'h600);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (empty_pipeline_reqE) cnt++;
    end
    check("mie_masked_req", 103'(cnt), 103'(0));

    // Drain timeout: line dropped after capture, cause still used.
    do_reset();
    apply(7'b0101100, 32'h700);
    tick();
    check("timeout_req", 103'(empty_pipeline_reqE), 103'(1));
    apply(7'b0001100, 32'h0);
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (excp_mepc_ena) begin
        found = k;
        break;
      end
    end
    check("timeout_latency", 103'(found), 103'(ACK_TIMEOUT + 1));
    check("timeout_strobe", {103'(drain_err), excp_mepc, mcause},
          {103'(1), 32'h700, 32'h8000_000B});
    repeat (10) tick();
    check("drain_err_sticky", 103'(drain_err), 103'(1));
    do_reset();
    check("drain_err_cleared", 103'(drain_err), 103'(0));

    // Reset while draining discards the trap.
    apply(7'b0101100, 32'h800);
    tick();
    tick();
    check("pre_reset_drain", {100'(0), stallF, fsm_state[1:0]}, {100'(0), 1'b1, 2'd1});
    reset = 1'b0;
    tick();
    check("reset_mid_drain", {outs(), fsm_state}, {{OW{1'b0}}, 3'd0});
    reset = 1'b1;
    apply(7'b0001101, 32'h0);
    tick();
    apply(7'b0001100, 32'h0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (excp_mepc_ena || stallF) cnt++;
    end
    check("no_trap_after_reset", 103'(cnt), 103'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu6_trap_sequencer.md
# cpu6_trap_sequencer

Sequences the cpu6 datapath through interrupt entry and `mret` return. It qualifies timer and external interrupts against the CSR enable bits and drains the pipeline using the `empty_pipeline_reqE` / `empty_pipeline_ackW` handshake. It then redirects fetch to `mtvec`, with `mepc` written, or to `mepc` on return. It sits beside `cpu6_datapath`, drives that block's `excp_mepc*`, `mret_ena` and `empty_pipeline_reqE` inputs, and owns the fetch-stall and redirect path for traps.

## Interface
- `ACK_TIMEOUT`, default 15: maximum cycles spent waiting for the drain acknowledge, range 1..255.
- `HOLDOFF`, default 2: cycles after a redirect during which new interrupts are ignored, range 1..7.

- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-low. `reset==0` at a rising edge resets the block.
- `tmr_irq_r` in 1: timer interrupt level.
- `ext_irq_r` in 1: external interrupt level.
- `csr_mtie_r` in 1: mie.MTIE.
- `csr_meie_r` in 1: mie.MEIE.
- `csr_mstatus_mie_r` in 1: mstatus.MIE.
- `mret_reqE` in 1: an `mret` is in E this cycle.
- `resume_pcE` in 32: PC execution resumes at if a trap is taken now.
- `csr_mtvec` in 32: trap vector (direct mode only).
- `csr_mepc` in 32: return address.
- `empty_pipeline_ackW` in 1: drain request has reached W.
- `empty_pipeline_reqE` out 1: drain request, one-cycle pulse.
- `stallF` out 1: hold fetch and squash E issue.
- `excp_mepc` out 32: value for mepc.
- `excp_mepc_ena` out 1: mepc write strobe.
- `mcause` out 32: cause value.
- `mcause_ena` out 1: mcause write strobe.
- `mret_ena` out 1: mret commit strobe to the CSR file.
- `redirect_valid` out 1: load `redirect_pc` into the fetch PC.
- `redirect_pc` out 32: redirect target.
- `drain_err` out 1: sticky flag, set when the drain acknowledge timed out.

## Operation
- `pending = csr_mstatus_mie_r & ((ext_irq_r & csr_meie_r) | (tmr_irq_r & csr_mtie_r))`.
- Interrupt priority: external first (cause `32'h8000_000B`), then timer (cause `32'h8000_0007`).
- FSM states: IDLE, IRQ_DRAIN, IRQ_TRAP, RET_DRAIN, RET_JMP.
- **IDLE**
  - Holdoff counter nonzero: decrement it; ignore `pending`; `mret_reqE` is still honoured.
  - `mret_reqE=1`: go to RET_DRAIN. `mret` wins over a simultaneous `pending`.
  - Else `pending=1` with holdoff 0: capture `resume_pcE` into `epc_q` and the cause into `cause_q`, then go to IRQ_DRAIN.
- **IRQ_DRAIN / RET_DRAIN**
  - `stallF=1`.
  - `empty_pipeline_reqE=1` in the first cycle of the state only.
  - The wait counter counts from 0 each cycle.
  - Leave on `empty_pipeline_ackW=1`, or when the wait counter reaches `ACK_TIMEOUT`. On timeout, set `drain_err`.
  - Next state: IRQ_DRAIN goes to IRQ_TRAP; RET_DRAIN goes to RET_JMP.
- **IRQ_TRAP** (one cycle), then IDLE with holdoff loaded to `HOLDOFF`:
  - `stallF=1`.
  - `excp_mepc_ena=1`, `excp_mepc=epc_q`.
  - `mcause_ena=1`, `mcause=cause_q`.
  - `redirect_valid=1`, `redirect_pc={csr_mtvec[31:2],2'b00}`.
- **RET_JMP** (one cycle), then IDLE with holdoff loaded:
  - `stallF=1`.
  - `mret_ena=1`.
  - `redirect_valid=1`, `redirect_pc={csr_mepc[31:2],2'b00}`.
- `empty_pipeline_ackW` in IDLE, or outside the drain states, is ignored.
- Interrupt lines dropping during IRQ_DRAIN do not cancel the trap; the captured cause is used.
- `drain_err` is cleared only by reset.

## Timing
- All outputs are registered from state and flops, with no combinational input-to-output path.
- Exception: `redirect_pc` is muxed from the `csr_mtvec` / `csr_mepc` inputs during the strobe cycle.
- Reset values: state=IDLE, holdoff=0, wait counter=0. All strobes, `stallF`, `drain_err`, `empty_pipeline_reqE` are 0; `excp_mepc`, `mcause`, `redirect_pc` are 32'h0.
- Interrupt sequence:
  - `pending` sampled high at edge N.
  - Cycle N+1: IRQ_DRAIN, `empty_pipeline_reqE`=1, `stallF`=1.
  - Ack sampled at edge D.
  - Cycle D+1: IRQ_TRAP strobes.
  - Cycle D+2: IDLE, `stallF`=0.
  - With the nominal ack arriving 2 cycles after the request: `excp_mepc_ena` is asserted 4 cycles after `pending` is first sampled.
- Holdoff: `pending` is ignored at edges D+2 through D+1+`HOLDOFF`.
- Timeout: with no ack, the strobe state is entered in cycle N+2+`ACK_TIMEOUT`.
- Reset asserted in any state: IDLE on the next edge. No strobe may fire in that cycle, and the captured `epc_q` is discarded.

## Test plan
- **IRQ entry:** MIE=1, MEIE=1, `ext_irq_r` 0→1, `resume_pcE`=0x0000_0120, `csr_mtvec`=0x0000_0401, ack 2 cycles after req → one req pulse; then one cycle with `excp_mepc`=0x120, `mcause`=0x8000_000B, `redirect_pc`=0x400.
- **Priority:** `tmr_irq_r` and `ext_irq_r` both high with MTIE=MEIE=1 → `mcause`=0x8000_000B. Repeat with MEIE=0 → `mcause`=0x8000_0007. Repeat with MIE=0 → no req for 20 cycles.
- **mret:** `mret_reqE`=1 together with a pending interrupt, `csr_mepc`=0x0000_0124 → RET path taken; `mret_ena`=1 one cycle with `redirect_pc`=0x124; no `excp_mepc_ena`.
- **Timeout:** ack held 0 with `ACK_TIMEOUT`=15 → `excp_mepc_ena` in cycle N+17; `drain_err`=1 and stays 1 until reset.
- **Holdoff and spurious ack:** `ext_irq_r` held high after a trap → next req no earlier than `HOLDOFF`+1 cycles after the IRQ_TRAP cycle; an ack pulse in IDLE causes no output change.
- **Reset mid-drain:** `reset`=0 during IRQ_DRAIN → IDLE with all outputs 0 on the next edge; no `excp_mepc_ena` occurs.
